// File: rtl/apb_master_bridge.sv
// APB requester: converts single-beat local commands into APB SETUP/ACCESS transfers
// and returns a one-cycle response carrying read data, slave error and timeout status.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR_m_s,
  output logic                  PWRITE_m_s,
  output logic                  PSEL_m_s,
  output logic                  PENABLE_m_s,
  output logic [DATA_WIDTH-1:0] PWDATA_m_s,
  input  logic                  PREADY_s_m,
  input  logic                  PSLVERR_s_m,
  input  logic [DATA_WIDTH-1:0] PRDATA_s_m
);

  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST));

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwdata_d      = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        // A ready slave wins over a timeout expiring on the same edge.
        if (PREADY_s_m) begin
          state_d       = ST_DONE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR_s_m;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !PSLVERR_s_m) ? PRDATA_s_m : '0;
        end else if (timeout_hit) begin
          state_d       = ST_DONE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwdata_q      <= pwdata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR_m_s   = paddr_q;
  assign PWRITE_m_s  = pwrite_q;
  assign PSEL_m_s    = psel_q;
  assign PENABLE_m_s = penable_q;
  assign PWDATA_m_s  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed and randomized transfers against a
// transaction-level model of a small APB memory slave with wait states.
module tb_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
  localparam logic [31:0] MAX_ADDR = 32'h3C;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR_m_s;
  logic          PWRITE_m_s, PSEL_m_s, PENABLE_m_s;
  logic [DW-1:0] PWDATA_m_s;
  logic          PREADY_s_m, PSLVERR_s_m;
  logic [DW-1:0] PRDATA_s_m;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [16];

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR_m_s(PADDR_m_s), .PWRITE_m_s(PWRITE_m_s), .PSEL_m_s(PSEL_m_s),
    .PENABLE_m_s(PENABLE_m_s), .PWDATA_m_s(PWDATA_m_s),
    .PREADY_s_m(PREADY_s_m), .PSLVERR_s_m(PSLVERR_s_m), .PRDATA_s_m(PRDATA_s_m)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer; the slave inserts `waits` wait states before PREADY.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits);
    logic        exp_to, exp_err;
    logic [31:0] exp_rd;
    int          n_edges;
    logic        slv_err;
    slv_err = (addr > MAX_ADDR);
    exp_to  = (waits >= int'(TO));
    n_edges = exp_to ? int'(TO) : waits + 1;
    exp_err = exp_to | slv_err;
    exp_rd  = (wr || exp_err) ? 32'h0 : mem[addr[5:2]];

    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    chk("setup_psel", 32'(PSEL_m_s), 32'd1);
    chk("setup_penable", 32'(PENABLE_m_s), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_paddr", PADDR_m_s, addr);
    chk("setup_pwrite", 32'(PWRITE_m_s), 32'(wr));
    chk("setup_pwdata", PWDATA_m_s, wr ? wdata : 32'h0);
    tick();
    for (int k = 0; k < n_edges; k++) begin
      chk("access_penable", 32'(PENABLE_m_s), 32'd1);
      chk("access_psel", 32'(PSEL_m_s), 32'd1);
      chk("access_paddr", PADDR_m_s, addr);
      chk("access_pwdata", PWDATA_m_s, wr ? wdata : 32'h0);
      chk("access_no_rsp", 32'(rsp_valid), 32'd0);
      if (k == waits) begin
        PREADY_s_m = 1'b1; PSLVERR_s_m = slv_err;
        PRDATA_s_m = (wr || slv_err) ? $urandom : mem[addr[5:2]];
      end else begin
        PREADY_s_m = 1'b0; PSLVERR_s_m = $urandom; PRDATA_s_m = $urandom;
      end
      tick();
      PREADY_s_m = 1'b0;
    end
    chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("done_psel", 32'(PSEL_m_s), 32'd0);
    chk("done_penable", 32'(PENABLE_m_s), 32'd0);
    chk("done_rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("done_rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    chk("done_rsp_rdata", rsp_rdata, exp_rd);
    if (wr && !exp_err) mem[addr[5:2]] = wdata;
    tick();
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rsp_held", rsp_rdata, exp_rd);
  endtask

  initial begin
    int          acc_cyc[$];
    int          cyc;
    int          got;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY_s_m = 1'b0; PSLVERR_s_m = 1'b0; PRDATA_s_m = '0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel", 32'(PSEL_m_s), 32'd0);
    chk("rst_penable", 32'(PENABLE_m_s), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_paddr", PADDR_m_s, 32'h0);
    PRESETn = 1'b1;
    tick();

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0);   // zero-wait write
    xfer(1'b0, 32'h10, 32'h0, 3);          // read back through 3 wait states
    xfer(1'b0, 32'h80, 32'h0, 1);          // out-of-range read -> slave error
    xfer(1'b0, 32'h10, 32'h0, 20);         // PREADY stuck low -> timeout
    xfer(1'b1, 32'h14, 32'h12345678, int'(TO) - 1);  // PREADY on last allowed cycle

    // Reset during ACCESS drops the transfer without a response.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hCAFE;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid_in_access", 32'(PENABLE_m_s), 32'd1);
    PRESETn = 1'b0;
    tick();
    chk("rst_mid_psel", 32'(PSEL_m_s), 32'd0);
    chk("rst_mid_penable", 32'(PENABLE_m_s), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    PRESETn = 1'b1; PREADY_s_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Three back-to-back commands with cmd_valid held and a zero-wait slave.
    PREADY_s_m = 1'b1; PSLVERR_s_m = 1'b0; PRDATA_s_m = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h5A5A5A5A;
    got = 0;
    for (cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (cmd_ready) begin
        got++;
        acc_cyc.push_back(cyc);
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(got), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    end
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_idle", 32'(cmd_ready), 32'd1);
    mem[8] = 32'h5A5A5A5A;
    PREADY_s_m = 1'b0;

    // Randomized traffic against the memory model, including errors and timeouts.
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 19)) << 2;
      xfer(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
